// File: rtl/boot_host_uploader.sv
// boot_host_uploader: streams a WORDS x 16-bit ROM image out over UART 8N1 (high byte first)
// and assembles the returned dump words. Define VERIFY_EN to add dump-vs-ROM checking
// (mismatch, err_count); the RX side then drives the ROM address while the uploader is idle.
module boot_host_uploader #(
    parameter int BAUD_DIV = 868,
    parameter int WORDS    = 64,
    parameter int ADR_W    = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce,
    input  logic             start,
    output logic [ADR_W-1:0] prog_adr,
    input  logic [15:0]      prog_data,
    output logic             tx,
    input  logic             rx,
    output logic             busy,
    output logic             upload_done,
    output logic             dump_valid,
    output logic [ADR_W-1:0] dump_adr,
    output logic [15:0]      dump_data,
    output logic             frame_err
`ifdef VERIFY_EN
    ,
    output logic             mismatch,
    output logic [ADR_W:0]   err_count
`endif
);
    localparam logic [15:0]      BIT_LAST  = 16'(BAUD_DIV - 1);
    localparam logic [15:0]      HALF_LAST = 16'(BAUD_DIV / 2 - 1);
    localparam logic [ADR_W-1:0] ADR_LAST  = ADR_W'(WORDS - 1);

    typedef enum logic [2:0] {T_IDLE, T_FETCH, T_LATCH, T_HI, T_LO, T_DONE} tx_st_t;
    typedef enum logic [2:0] {R_HUNT, R_START, R_DATA, R_STOP, R_WAIT} rx_st_t;

    tx_st_t           ts_q, ts_d;
    logic [ADR_W-1:0] tadr_q, tadr_d;
    logic [9:0]       sh_q, sh_d;
    logic [7:0]       lo_q, lo_d;
    logic [15:0]      tbc_q, tbc_d;
    logic [3:0]       tbn_q, tbn_d;
    logic             busy_q, busy_d, done_q, done_d;
    logic             rs1_q, rs2_q, rp_q;
    rx_st_t           rxs_q, rxs_d;
    logic [15:0]      rbc_q, rbc_d;
    logic [2:0]       rbn_q, rbn_d;
    logic [7:0]       rsh_q, rsh_d, hi_q, hi_d;
    logic             ph_q, ph_d, dv_q, dv_d, ferr_q, ferr_d;
    logic [ADR_W-1:0] dadr_q, dadr_d;
    logic [15:0]      ddata_q, ddata_d;
    logic             start_acc;
`ifdef VERIFY_EN
    logic             mis_q, mis_d;
    logic [ADR_W:0]   ecnt_q, ecnt_d;
`endif

    assign start_acc = start && ts_q == T_IDLE;

    // Upload sequencer: per word FETCH, LATCH, 10-bit high frame, 10-bit low frame plus one idle cycle
    always_comb begin
        ts_d   = ts_q;
        tadr_d = tadr_q;
        sh_d   = sh_q;
        lo_d   = lo_q;
        tbc_d  = tbc_q;
        tbn_d  = tbn_q;
        busy_d = busy_q;
        done_d = 1'b0;
        case (ts_q)
            T_IDLE: if (start) begin
                ts_d   = T_FETCH;
                busy_d = 1'b1;
                tadr_d = '0;
            end
            T_FETCH: ts_d = T_LATCH;
            T_LATCH: begin
                sh_d  = {1'b1, prog_data[15:8], 1'b0};
                lo_d  = prog_data[7:0];
                tbc_d = '0;
                tbn_d = '0;
                ts_d  = T_HI;
            end
            T_HI: begin
                tbc_d = tbc_q == BIT_LAST ? '0 : tbc_q + 16'd1;
                if (tbc_q == BIT_LAST) begin
                    sh_d  = tbn_q == 4'd9 ? {1'b1, lo_q, 1'b0} : {1'b1, sh_q[9:1]};
                    tbn_d = tbn_q == 4'd9 ? 4'd0 : tbn_q + 4'd1;
                    ts_d  = tbn_q == 4'd9 ? T_LO : T_HI;
                end
            end
            T_LO: if (tbn_q == 4'd10) begin
                ts_d   = tadr_q == ADR_LAST ? T_DONE : T_FETCH;
                tadr_d = tadr_q == ADR_LAST ? tadr_q : tadr_q + 1'b1;
                busy_d = tadr_q != ADR_LAST;
                done_d = tadr_q == ADR_LAST;
            end else begin
                tbc_d = tbc_q == BIT_LAST ? '0 : tbc_q + 16'd1;
                if (tbc_q == BIT_LAST) begin
                    sh_d  = {1'b1, sh_q[9:1]};
                    tbn_d = tbn_q + 4'd1;
                end
            end
            T_DONE: ts_d = T_IDLE;
            default: ts_d = T_IDLE;
        endcase
    end

    // Dump receiver: mid-bit sampling, byte pairing high-then-low, framing error tracking
    always_comb begin
        rxs_d   = rxs_q;
        rbc_d   = rbc_q;
        rbn_d   = rbn_q;
        rsh_d   = rsh_q;
        hi_d    = hi_q;
        ph_d    = ph_q;
        dv_d    = 1'b0;
        ddata_d = ddata_q;
        dadr_d  = dv_q ? (dadr_q == ADR_LAST ? '0 : dadr_q + 1'b1) : dadr_q;
        ferr_d  = ferr_q && !start_acc;
`ifdef VERIFY_EN
        mis_d   = mis_q && !start_acc;
        ecnt_d  = start_acc ? '0 : ecnt_q;
`endif
        case (rxs_q)
            R_HUNT: if (rp_q && !rs2_q) begin
                rxs_d = R_START;
                rbc_d = '0;
            end
            R_START: if (rbc_q == HALF_LAST) begin
                rbc_d  = '0;
                rbn_d  = '0;
                rxs_d  = rs2_q ? R_HUNT : R_DATA;
                ferr_d = ferr_d || rs2_q;
                ph_d   = ph_q && !rs2_q;
            end else rbc_d = rbc_q + 16'd1;
            R_DATA: if (rbc_q == BIT_LAST) begin
                rbc_d = '0;
                rsh_d = {rs2_q, rsh_q[7:1]};
                rbn_d = rbn_q + 3'd1;
                rxs_d = rbn_q == 3'd7 ? R_STOP : R_DATA;
            end else rbc_d = rbc_q + 16'd1;
            R_STOP: if (rbc_q == BIT_LAST) begin
                rbc_d = '0;
                if (!rs2_q) begin
                    ferr_d = 1'b1;
                    ph_d   = 1'b0;
                    rxs_d  = R_WAIT;
                end else begin
                    rxs_d = R_HUNT;
                    ph_d  = !ph_q;
                    hi_d  = ph_q ? hi_q : rsh_q;
                    if (ph_q) begin
                        dv_d    = 1'b1;
                        ddata_d = {hi_q, rsh_q};
`ifdef VERIFY_EN
                        if (!busy_q && {hi_q, rsh_q} != prog_data) begin
                            mis_d  = 1'b1;
                            ecnt_d = &ecnt_q ? ecnt_q : ecnt_q + 1'b1;
                        end
`endif
                    end
                end
            end else rbc_d = rbc_q + 16'd1;
            R_WAIT: if (rs2_q) rxs_d = R_HUNT;
            default: rxs_d = R_HUNT;
        endcase
    end

    // All state: synchronous active-low reset, frozen while ce is low
    always_ff @(posedge clk) begin
        if (!rst) begin
            ts_q    <= T_IDLE;
            tadr_q  <= '0;
            sh_q    <= '1;
            lo_q    <= '0;
            tbc_q   <= '0;
            tbn_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            rs1_q   <= 1'b1;
            rs2_q   <= 1'b1;
            rp_q    <= 1'b1;
            rxs_q   <= R_HUNT;
            rbc_q   <= '0;
            rbn_q   <= '0;
            rsh_q   <= '0;
            hi_q    <= '0;
            ph_q    <= 1'b0;
            dv_q    <= 1'b0;
            dadr_q  <= '0;
            ddata_q <= '0;
            ferr_q  <= 1'b0;
`ifdef VERIFY_EN
            mis_q   <= 1'b0;
            ecnt_q  <= '0;
`endif
        end else if (ce) begin
            ts_q    <= ts_d;
            tadr_q  <= tadr_d;
            sh_q    <= sh_d;
            lo_q    <= lo_d;
            tbc_q   <= tbc_d;
            tbn_q   <= tbn_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            rs1_q   <= rx;
            rs2_q   <= rs1_q;
            rp_q    <= rs2_q;
            rxs_q   <= rxs_d;
            rbc_q   <= rbc_d;
            rbn_q   <= rbn_d;
            rsh_q   <= rsh_d;
            hi_q    <= hi_d;
            ph_q    <= ph_d;
            dv_q    <= dv_d;
            dadr_q  <= dadr_d;
            ddata_q <= ddata_d;
            ferr_q  <= ferr_d;
`ifdef VERIFY_EN
            mis_q   <= mis_d;
            ecnt_q  <= ecnt_d;
`endif
        end
    end

    assign tx          = sh_q[0];
    assign busy        = busy_q;
    assign upload_done = done_q;
    assign dump_valid  = dv_q;
    assign dump_adr    = dadr_q;
    assign dump_data   = ddata_q;
    assign frame_err   = ferr_q;
`ifdef VERIFY_EN
    assign prog_adr    = busy_q ? tadr_q : dadr_q;
    assign mismatch    = mis_q;
    assign err_count   = ecnt_q;
`else
    assign prog_adr    = tadr_q;
`endif
endmodule
